// File: rtl/imem_load_ctrl.sv
// Framed instruction-memory loader: collects 7-byte {address, data} frames from the pad bus
// and issues one single-cycle instruction-memory write per committed frame.
module imem_load_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_int,
  input  logic                  reset_n,
  input  logic                  mode_memload,
  input  logic [7:0]            byte_in,
  input  logic                  byte_strobe,
  input  logic                  commit,
  output logic [ADDR_WIDTH-1:0] imem_write_adr,
  output logic [DATA_WIDTH-1:0] imem_in,
  output logic                  imem_write_en,
  output logic                  load_busy,
  output logic                  frame_error,
  output logic [2:0]            byte_count
);

  localparam int unsigned HoldW = 56;

  typedef enum logic [2:0] {StIdle, StCollect, StFull, StWrite, StError} state_e;

  logic [SYNC_STAGES-1:0]      strb_sync_q, cmt_sync_q;
  logic [SYNC_STAGES-1:0][7:0] byte_sync_q;
  logic                        strb_prev_q, cmt_prev_q;
  logic                        strb_edge, cmt_edge;
  logic [7:0]                  sync_byte;

  state_e                      state_q;
  logic [2:0]                  count_q;
  logic [HoldW-1:0]            hold_q;
  logic [ADDR_WIDTH-1:0]       adr_q;
  logic [DATA_WIDTH-1:0]       data_q;
  logic                        we_q, busy_q, err_q;
  logic [15:0]                 adr_full;
  logic                        adr_hi_nz;

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      strb_sync_q <= '0;
      cmt_sync_q  <= '0;
      byte_sync_q <= '0;
      strb_prev_q <= 1'b0;
      cmt_prev_q  <= 1'b0;
    end else begin
      strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], byte_strobe};
      cmt_sync_q  <= {cmt_sync_q[SYNC_STAGES-2:0], commit};
      byte_sync_q <= {byte_sync_q[SYNC_STAGES-2:0], byte_in};
      strb_prev_q <= strb_sync_q[SYNC_STAGES-1];
      cmt_prev_q  <= cmt_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    strb_edge = strb_sync_q[SYNC_STAGES-1] & ~strb_prev_q;
    cmt_edge  = cmt_sync_q[SYNC_STAGES-1] & ~cmt_prev_q;
    sync_byte = byte_sync_q[SYNC_STAGES-1];
    adr_full  = hold_q[HoldW-1 -: 16];
    // Any address bit above ADDR_WIDTH makes the frame unwritable.
    adr_hi_nz = (adr_full >> ADDR_WIDTH) != 16'd0;
  end

  always_ff @(posedge clk_int or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      hold_q  <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (!mode_memload) begin
        state_q <= StIdle;
        count_q <= '0;
        busy_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle, StCollect: begin
            if (cmt_edge) begin
              state_q <= StError;
              count_q <= '0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (strb_edge) begin
              hold_q  <= {hold_q[HoldW-9:0], sync_byte};
              count_q <= count_q + 3'd1;
              busy_q  <= 1'b1;
              state_q <= (count_q == 3'd6) ? StFull : StCollect;
            end
          end
          StFull: begin
            if (cmt_edge && !strb_edge && !adr_hi_nz) begin
              state_q <= StWrite;
              adr_q   <= hold_q[DATA_WIDTH +: ADDR_WIDTH];
              data_q  <= hold_q[DATA_WIDTH-1:0];
              we_q    <= 1'b1;
              count_q <= '0;
              busy_q  <= 1'b0;
            end else if (strb_edge || cmt_edge) begin
              state_q <= StError;
              count_q <= '0;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
          StWrite: begin
            state_q <= StIdle;
          end
          StError: begin
            count_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_write_adr = adr_q;
  assign imem_in        = data_q;
  assign imem_write_en  = we_q;
  assign load_busy      = busy_q;
  assign frame_error    = err_q;
  assign byte_count     = count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed vector table, hand-written corner sequences and random
// pad-event traffic checked against a frame-level reference model.
module tb_imem_load_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 40;

  logic          clk_int = 1'b0;
  logic          reset_n = 1'b0;
  logic          mode_memload = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_strobe = 1'b0;
  logic          commit = 1'b0;
  logic [AW-1:0] imem_write_adr;
  logic [DW-1:0] imem_in;
  logic          imem_write_en, load_busy, frame_error;
  logic [2:0]    byte_count;

  always #5 clk_int = ~clk_int;

  imem_load_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_int        (clk_int),
    .reset_n        (reset_n),
    .mode_memload   (mode_memload),
    .byte_in        (byte_in),
    .byte_strobe    (byte_strobe),
    .commit         (commit),
    .imem_write_adr (imem_write_adr),
    .imem_in        (imem_in),
    .imem_write_en  (imem_write_en),
    .load_busy      (load_busy),
    .frame_error    (frame_error),
    .byte_count     (byte_count)
  );

  typedef enum int {EvByte, EvCommit, EvMode, EvBoth} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] val;
    logic [2:0] cnt;
    logic       busy;
    logic       err;
    int         pulse;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   pulses = 0;
  logic we_prev = 1'b0;
  vec_t tbl[$];

  // Frame-level reference model
  logic [7:0]    m_bytes[$];
  logic          m_err = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_int);
  endtask

  always @(negedge clk_int) begin
    if (imem_write_en) begin
      pulses++;
      check("we_single_cycle", {63'd0, we_prev}, 64'd0);
    end
    we_prev = imem_write_en;
  end

  function automatic int model_step(input ev_e k, input logic [7:0] v);
    int a;
    logic [DW-1:0] d;
    model_step = 0;
    case (k)
      EvMode: begin
        m_bytes.delete();
        m_err = 1'b0;
      end
      EvByte: if (!m_err) begin
        if (m_bytes.size() < 7) m_bytes.push_back(v);
        else begin
          m_bytes.delete();
          m_err = 1'b1;
        end
      end
      EvCommit: if (!m_err) begin
        a = (m_bytes.size() == 7) ? int'(m_bytes[0]) * 256 + int'(m_bytes[1]) : 0;
        if (m_bytes.size() == 7 && a < (1 << AW)) begin
          d = '0;
          for (int i = 2; i < 7; i++) d = (d << 8) | DW'(m_bytes[i]);
          m_adr = a[AW-1:0];
          m_data = d;
          model_step = 1;
        end else m_err = 1'b1;
        m_bytes.delete();
      end
      EvBoth: if (!m_err) begin
        m_bytes.delete();
        m_err = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic apply(input ev_e k, input logic [7:0] v, output int got_p);
    int p0;
    int exp_p;
    p0 = pulses;
    case (k)
      EvByte: begin
        byte_in = v;
        wait_cyc(3);
        byte_strobe = 1'b1;
        wait_cyc(4);
        byte_strobe = 1'b0;
        byte_in = ~v;
        wait_cyc(3);
      end
      EvCommit: begin
        commit = 1'b1;
        wait_cyc(4);
        commit = 1'b0;
        wait_cyc(3);
      end
      EvBoth: begin
        byte_strobe = 1'b1;
        commit = 1'b1;
        wait_cyc(4);
        byte_strobe = 1'b0;
        commit = 1'b0;
        wait_cyc(3);
      end
      default: begin
        mode_memload = 1'b0;
        wait_cyc(1);
        mode_memload = 1'b1;
        wait_cyc(2);
      end
    endcase
    exp_p = model_step(k, v);
    got_p = pulses - p0;
    check("pulse_count", 64'(got_p), 64'(exp_p));
    check("byte_count", 64'(byte_count), 64'(m_bytes.size()));
    check("load_busy", 64'(load_busy), 64'(!m_err && m_bytes.size() > 0));
    check("frame_error", 64'(frame_error), 64'(m_err));
    check("imem_write_adr", 64'(imem_write_adr), 64'(m_adr));
    check("imem_in", 64'(imem_in), 64'(m_data));
    check("we_idle", 64'(imem_write_en), 64'd0);
  endtask

  function automatic vec_t mk(input ev_e k, input logic [7:0] v, input int c, input bit b,
                              input bit e, input int p);
    vec_t t;
    t.kind = k; t.val = v; t.cnt = 3'(c); t.busy = b; t.err = e; t.pulse = p;
    return t;
  endfunction

  function automatic void add_bytes(input logic [55:0] f, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(mk(EvByte, f[55-8*i -: 8], i + 1, 1, 0, 0));
  endfunction

  function automatic void add_frame(input logic [55:0] f, input bit ok);
    add_bytes(f, 7);
    tbl.push_back(mk(EvCommit, 8'h00, 0, 0, !ok, ok ? 1 : 0));
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_adr"}, 64'(imem_write_adr), 64'd0);
    check({tag, "_data"}, 64'(imem_in), 64'd0);
    check({tag, "_we"}, 64'(imem_write_en), 64'd0);
    check({tag, "_busy"}, 64'(load_busy), 64'd0);
    check({tag, "_err"}, 64'(frame_error), 64'd0);
    check({tag, "_cnt"}, 64'(byte_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int   gp;
    ev_e  k;
    logic [7:0] v;

    wait_cyc(2);
    check_all_zero("reset");
    reset_n = 1'b1;
    mode_memload = 1'b1;
    wait_cyc(2);

    add_frame(56'h0123DEADBEEF42, 1);
    add_frame(56'h00000000000001, 1);
    add_frame(56'h03FFFFFFFFFFFF, 1);
    add_bytes(56'h0102030405AAAA, 4);
    tbl.push_back(mk(EvCommit, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(EvByte, 8'h55, 0, 0, 1, 0));
    tbl.push_back(mk(EvCommit, 8'h00, 0, 0, 1, 0));
    tbl.push_back(mk(EvMode, 8'h00, 0, 0, 0, 0));
    add_bytes(56'h02001122334455, 7);
    tbl.push_back(mk(EvByte, 8'h66, 0, 0, 1, 0));
    tbl.push_back(mk(EvMode, 8'h00, 0, 0, 0, 0));
    add_frame(56'h04001122334455, 0);
    tbl.push_back(mk(EvMode, 8'h00, 0, 0, 0, 0));
    add_bytes(56'h01020300000000, 3);
    tbl.push_back(mk(EvMode, 8'h00, 0, 0, 0, 0));
    add_frame(56'h02AB1122334455, 1);

    foreach (tbl[i]) begin
      apply(tbl[i].kind, tbl[i].val, gp);
      check("tbl_cnt", 64'(byte_count), 64'(tbl[i].cnt));
      check("tbl_busy", 64'(load_busy), 64'(tbl[i].busy));
      check("tbl_err", 64'(frame_error), 64'(tbl[i].err));
      check("tbl_pulse", 64'(gp), 64'(tbl[i].pulse));
    end
    check("final_adr", 64'(imem_write_adr), 64'h2AB);
    check("final_data", 64'(imem_in), 64'h1122334455);

    // Asynchronous reset between clock edges, mid-frame
    apply(EvByte, 8'h01, gp);
    apply(EvByte, 8'h55, gp);
    apply(EvByte, 8'h66, gp);
    @(posedge clk_int);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_bytes.delete();
    m_err = 1'b0;
    m_adr = '0;
    m_data = '0;
    #2;
    reset_n = 1'b1;
    wait_cyc(2);

    // Strobe and commit together from FULL
    for (int i = 0; i < 7; i++) apply(EvByte, 8'(i + 1), gp);
    check("full_cnt", 64'(byte_count), 64'd7);
    apply(EvBoth, 8'h00, gp);
    check("both_err", 64'(frame_error), 64'd1);
    check("both_pulse", 64'(gp), 64'd0);
    apply(EvMode, 8'h00, gp);

    for (int n = 0; n < 200; n++) begin
      if (m_bytes.size() == 7 && $urandom_range(0, 9) < 7) k = EvCommit;
      else begin
        case ($urandom_range(0, 19))
          0, 1:    k = EvCommit;
          2:       k = EvMode;
          3:       k = EvBoth;
          default: k = EvByte;
        endcase
      end
      v = 8'($urandom);
      if (k == EvByte && m_bytes.size() == 0 && $urandom_range(0, 9) != 0) v = v & 8'h03;
      apply(k, v, gp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
